// File: rtl/asrv32_memoryaccess_pkg.sv
// rtl/asrv32_memoryaccess_pkg.sv - shared types, opcode indices and alignment helper
`include "asrv32_header.vh"

package asrv32_memoryaccess_pkg;

  localparam int OPCODE_WIDTH = `OPCODE_WIDTH;
  localparam int OP_RTYPE     = `OP_RTYPE;
  localparam int OP_LOAD      = `OP_LOAD;
  localparam int OP_STORE     = `OP_STORE;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      `SIZE_HALF: is_misaligned = addr_lo[0];
      `SIZE_WORD: is_misaligned = (addr_lo != 2'b00);
      default:    is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/asrv32_memoryaccess_if.sv
// rtl/asrv32_memoryaccess_if.sv - data-bus signal bundle between memory stage and bus slave
interface asrv32_memoryaccess_if;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_ack;
  logic [31:0] i_wb_data;

  modport master (
    output o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    input  i_wb_ack, i_wb_data
  );

  modport slave (
    input  o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    output i_wb_ack, i_wb_data
  );
endinterface

// File: rtl/asrv32_header.vh
// rtl/asrv32_header.vh - funct3 access-size encodings and one-hot opcode bit indices
`ifndef ASRV32_HEADER_VH
`define ASRV32_HEADER_VH

`define OPCODE_WIDTH 11

`define OP_RTYPE  0
`define OP_ITYPE  1
`define OP_LOAD   2
`define OP_STORE  3
`define OP_BRANCH 4
`define OP_JAL    5
`define OP_JALR   6
`define OP_LUI    7
`define OP_AUIPC  8
`define OP_SYSTEM 9
`define OP_FENCE  10

`define SIZE_BYTE 2'b00
`define SIZE_HALF 2'b01
`define SIZE_WORD 2'b10

`define FUNCT3_LB  3'b000
`define FUNCT3_LH  3'b001
`define FUNCT3_LW  3'b010
`define FUNCT3_LBU 3'b100
`define FUNCT3_LHU 3'b101

`endif

// File: rtl/asrv32_lsu_align.sv
// rtl/asrv32_lsu_align.sv - store lane replication/byte enables and load extract/extend
`include "asrv32_header.vh"

module asrv32_lsu_align (
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_addr_lo,
  input  logic [31:0] i_rs2_data,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_sel,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  logic [1:0]  w_ld_off;
  logic [31:0] w_shifted;

  always_comb begin
    o_sel   = 4'b1111;
    o_wdata = i_rs2_data;
    case (i_st_size)
      `SIZE_BYTE: begin
        o_sel   = 4'b0001 << i_st_addr_lo;
        o_wdata = {4{i_rs2_data[7:0]}};
      end
      `SIZE_HALF: begin
        o_sel   = 4'b0011 << {i_st_addr_lo[1], 1'b0};
        o_wdata = {2{i_rs2_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Offset bits that an access size cannot use are ignored rather than trapped.
  always_comb begin
    case (i_ld_funct3[1:0])
      `SIZE_BYTE: w_ld_off = i_ld_addr_lo;
      `SIZE_HALF: w_ld_off = {i_ld_addr_lo[1], 1'b0};
      default:    w_ld_off = 2'b00;
    endcase
  end

  assign w_shifted = i_rdata >> {w_ld_off, 3'b000};

  always_comb begin
    case (i_ld_funct3)
      `FUNCT3_LB:  o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      `FUNCT3_LH:  o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      `FUNCT3_LBU: o_load_data = {24'd0, w_shifted[7:0]};
      `FUNCT3_LHU: o_load_data = {16'd0, w_shifted[15:0]};
      default:     o_load_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/asrv32_memoryaccess.sv
// rtl/asrv32_memoryaccess.sv - RV32 memory-access stage with single-outstanding bus FSM
// Optional misaligned-access trap enabled by defining ASRV32_MISALIGN_TRAP_EN.
module asrv32_memoryaccess
  import asrv32_memoryaccess_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [31:0]             i_result_from_alu,
  input  logic [31:0]             i_rs2_data,
  input  logic [2:0]              i_funct3,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  input  logic [31:0]             i_pc,
  input  logic                    i_wr_rd_en,
  input  logic [4:0]              i_rd_addr,
  output logic [2:0]              o_funct3,
  output logic [OPCODE_WIDTH-1:0] o_opcode,
  output logic [31:0]             o_pc,
  output logic                    o_wr_rd_en,
  output logic [4:0]              o_rd_addr,
  output logic [31:0]             o_rd_data,
  output logic [31:0]             o_load_data,
  asrv32_memoryaccess_if.master   wb,
  input  logic                    i_ce,
  output logic                    o_ce,
  input  logic                    i_stall,
  output logic                    o_stall,
  input  logic                    i_flush
`ifdef ASRV32_MISALIGN_TRAP_EN
  ,
  output logic                    o_misaligned
`endif
);

  state_t                  r_state;
  logic                    r_done;
  logic                    r_killed;
  logic [31:0]             r_req_addr;
  logic [31:0]             r_req_pc;
  logic [2:0]              r_req_funct3;
  logic [OPCODE_WIDTH-1:0] r_req_opcode;
  logic [4:0]              r_req_rd;
  logic                    r_req_wr;
  logic [31:0]             r_ld_buf;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_mem;
  logic        w_misaligned;
  logic        w_issue;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;

  assign w_is_load  = i_opcode[OP_LOAD];
  assign w_is_store = i_opcode[OP_STORE];
  assign w_mem      = w_is_load | w_is_store;

`ifdef ASRV32_MISALIGN_TRAP_EN
  assign w_misaligned = w_mem & is_misaligned(i_funct3, i_result_from_alu[1:0]);
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_issue = (r_state == ST_IDLE) & ~r_done & i_ce & ~i_stall & ~i_flush & w_mem & ~w_misaligned;
  // r_done keeps the upstream frozen until a stalled load result is handed on.
  assign o_stall = w_issue | r_done | ((r_state == ST_WAIT) & ~wb.i_wb_ack);

  asrv32_lsu_align u_align (
    .i_st_size    (i_funct3[1:0]),
    .i_st_addr_lo (i_result_from_alu[1:0]),
    .i_rs2_data   (i_rs2_data),
    .i_ld_funct3  (r_req_funct3),
    .i_ld_addr_lo (r_req_addr[1:0]),
    .i_rdata      (wb.i_wb_data),
    .o_sel        (w_sel),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_done       <= 1'b0;
      r_killed     <= 1'b0;
      r_req_addr   <= '0;
      r_req_pc     <= '0;
      r_req_funct3 <= '0;
      r_req_opcode <= '0;
      r_req_rd     <= '0;
      r_req_wr     <= 1'b0;
      r_ld_buf     <= '0;
      o_funct3     <= '0;
      o_opcode     <= '0;
      o_pc         <= '0;
      o_wr_rd_en   <= 1'b0;
      o_rd_addr    <= '0;
      o_rd_data    <= '0;
      o_load_data  <= '0;
      o_ce         <= 1'b0;
      wb.o_wb_stb  <= 1'b0;
      wb.o_wb_we   <= 1'b0;
      wb.o_wb_addr <= '0;
      wb.o_wb_data <= '0;
      wb.o_wb_sel  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_done) begin
            o_ce <= 1'b0;
            if (i_flush) begin
              r_done     <= 1'b0;
              o_wr_rd_en <= 1'b0;
            end else if (!i_stall) begin
              r_done      <= 1'b0;
              o_funct3    <= r_req_funct3;
              o_opcode    <= r_req_opcode;
              o_pc        <= r_req_pc;
              o_rd_addr   <= r_req_rd;
              o_rd_data   <= r_req_addr;
              o_wr_rd_en  <= r_req_wr;
              o_load_data <= r_ld_buf;
              o_ce        <= 1'b1;
            end
          end else if (w_issue) begin
            wb.o_wb_stb  <= 1'b1;
            wb.o_wb_we   <= w_is_store;
            wb.o_wb_addr <= {i_result_from_alu[31:2], 2'b00};
            wb.o_wb_sel  <= w_sel;
            wb.o_wb_data <= w_wdata;
            r_req_addr   <= i_result_from_alu;
            r_req_pc     <= i_pc;
            r_req_funct3 <= i_funct3;
            r_req_opcode <= i_opcode;
            r_req_rd     <= i_rd_addr;
            r_req_wr     <= i_wr_rd_en & w_is_load;
            r_killed     <= 1'b0;
            o_ce         <= 1'b0;
            r_state      <= ST_WAIT;
          end else if (i_flush) begin
            o_ce       <= 1'b0;
            o_wr_rd_en <= 1'b0;
          end else if (i_stall) begin
            o_ce <= 1'b0;
          end else begin
            o_funct3   <= i_funct3;
            o_opcode   <= i_opcode;
            o_pc       <= i_pc;
            o_rd_addr  <= i_rd_addr;
            o_rd_data  <= i_result_from_alu;
            o_wr_rd_en <= i_wr_rd_en & i_ce & ~w_is_store & ~w_misaligned;
            o_ce       <= i_ce;
          end
        end

        ST_WAIT: begin
          o_ce <= 1'b0;
          if (i_flush) begin
            r_killed   <= 1'b1;
            o_wr_rd_en <= 1'b0;
          end
          // A flushed access still runs to its ack; only the result is dropped.
          if (wb.i_wb_ack) begin
            wb.o_wb_stb <= 1'b0;
            r_state     <= ST_IDLE;
            if (r_killed || i_flush) begin
              o_wr_rd_en <= 1'b0;
            end else if (i_stall) begin
              r_done   <= 1'b1;
              r_ld_buf <= w_load_data;
            end else begin
              o_funct3    <= r_req_funct3;
              o_opcode    <= r_req_opcode;
              o_pc        <= r_req_pc;
              o_rd_addr   <= r_req_rd;
              o_rd_data   <= r_req_addr;
              o_wr_rd_en  <= r_req_wr;
              o_load_data <= w_load_data;
              o_ce        <= 1'b1;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef ASRV32_MISALIGN_TRAP_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_misaligned <= 1'b0;
    end else if (i_flush) begin
      o_misaligned <= 1'b0;
    end else if (!i_stall) begin
      o_misaligned <= (r_state == ST_IDLE) & ~r_done & i_ce & w_misaligned;
    end
  end
`endif

endmodule
